fir_tap_sequencer: RTL and testbench

// Sequences one FIR output per accepted input sample. Per sample it:
// - pulses shift_enb so the shifting delay-line register file loads the sample;
// - walks pointer over taps 0..LENGTH-1 (sample and coefficient addresses), driving the external MAC;
// - waits out the MAC pipeline, then presents out_valid under a valid/ready handshake.

---
 rtl/fir_tap_sequencer_if.sv | 22 ++
 rtl/fir_tap_sequencer.sv | 120 ++++++++++++
 tb/tb_fir_tap_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in / result-out valid-ready handshake bundle for the FIR tap sequencer.
// master drives the upstream valid and downstream ready; slave is the sequencer.
interface fir_tap_sequencer_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: one delay-line shift, LENGTH MAC taps and a MAC drain
// per accepted sample, then a held result under a valid/ready handshake.
module fir_tap_sequencer #(
    parameter int LENGTH  = 100,
    parameter int ADDR_W  = 7,
    parameter int MAC_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    fir_tap_sequencer_if.slave hs,
    output logic              shift_enb,
    output logic [ADDR_W-1:0] pointer,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              acc_last,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int DW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LENGTH - 1);
    localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(LENGTH - 2);
    localparam logic [DW-1:0] DLAST =
        DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        MAC,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] drain;
    logic          in_ready;
    logic          out_valid;

    assign hs.in_ready  = in_ready;
    assign hs.out_valid = out_valid;

    // Outputs are registered alongside each transition, so they depend
    // only on flops and never on in_valid/out_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pointer    <= '0;
            drain      <= '0;
            sample_cnt <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            shift_enb  <= 1'b0;
            acc_clr    <= 1'b0;
            acc_en     <= 1'b0;
            acc_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs.in_valid && in_ready) begin
                        state     <= SHIFT;
                        in_ready  <= 1'b0;
                        shift_enb <= 1'b1;
                        acc_clr   <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                SHIFT: begin
                    state     <= MAC;
                    shift_enb <= 1'b0;
                    acc_clr   <= 1'b0;
                    acc_en    <= 1'b1;
                    acc_last  <= 1'b0;
                    pointer   <= '0;
                end
                MAC: begin
                    if (pointer == LAST) begin
                        pointer  <= '0;
                        drain    <= '0;
                        acc_en   <= 1'b0;
                        acc_last <= 1'b0;
                        if (MAC_LAT > 0) begin
                            state <= DRAIN;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        pointer  <= pointer + ADDR_W'(1);
                        acc_last <= (pointer == LAST1);
                    end
                end
                DRAIN: begin
                    if (drain == DLAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        drain <= drain + DW'(1);
                    end
                end
                DONE: begin
                    if (hs.out_ready) begin
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        busy       <= 1'b0;
                        in_ready   <= 1'b1;
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: default build plus a short
// zero-drain build and a 2-bit-counter build sharing clock and reset.
module tb_fir_tap_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fir_tap_sequencer_if if0 ();
    fir_tap_sequencer_if if1 ();
    fir_tap_sequencer_if if2 ();

    logic        shift0, clr0, en0, last0, busy0;
    logic [6:0]  ptr0;
    logic [15:0] cnt0;
    logic        shift1, clr1, en1, last1, busy1;
    logic [1:0]  ptr1;
    logic [15:0] cnt1;
    logic        shift2, clr2, en2, last2, busy2;
    logic [1:0]  ptr2;
    logic [1:0]  cnt2;

    fir_tap_sequencer u0 (
        .clk        (clk),
        .rst        (rst),
        .hs         (if0),
        .shift_enb  (shift0),
        .pointer    (ptr0),
        .acc_clr    (clr0),
        .acc_en     (en0),
        .acc_last   (last0),
        .busy       (busy0),
        .sample_cnt (cnt0)
    );

    fir_tap_sequencer #(
        .LENGTH (4), .ADDR_W (2), .MAC_LAT (0), .CNT_W (16)
    ) u1 (
        .clk        (clk),
        .rst        (rst),
        .hs         (if1),
        .shift_enb  (shift1),
        .pointer    (ptr1),
        .acc_clr    (clr1),
        .acc_en     (en1),
        .acc_last   (last1),
        .busy       (busy1),
        .sample_cnt (cnt1)
    );

    fir_tap_sequencer #(
        .LENGTH (4), .ADDR_W (2), .MAC_LAT (1), .CNT_W (2)
    ) u2 (
        .clk        (clk),
        .rst        (rst),
        .hs         (if2),
        .shift_enb  (shift2),
        .pointer    (ptr2),
        .acc_clr    (clr2),
        .acc_en     (en2),
        .acc_last   (last2),
        .busy       (busy2),
        .sample_cnt (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  pulses;
        int  stamp [5];
        bit  found;
        logic [1:0] seq [5];

        checks   = 0;
        failures = 0;
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3;
        seq[3] = 2'd0; seq[4] = 2'd1;

        rst = 1'b0;
        if0.in_valid = 1'b0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready", if0.in_ready, 0);
        check("rst_ovalid", if0.out_valid, 0);
        check("rst_busy", busy0, 0);
        check("rst_ptr", ptr0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_shift", shift0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", if0.in_ready, 1);
        check("idle_ptr", ptr0, 0);

        // single sample timing
        if0.out_ready = 1'b1;
        if0.in_valid  = 1'b1;
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        for (int c = 1; c <= 104; c++) begin
            @(negedge clk);
            check("t2_shift", shift0, c == 1);
            check("t2_clr", clr0, c == 1);
            check("t2_en", en0, c >= 2 && c <= 101);
            check("t2_ptr", ptr0, (c >= 2 && c <= 101) ? c - 2 : 0);
            check("t2_last", last0, c == 101);
            check("t2_ovalid", if0.out_valid, c == 104);
            check("t2_ready", if0.in_ready, 0);
        end
        @(negedge clk);
        check("t2_cnt", cnt0, 1);
        check("t2_busy", busy0, 0);
        check("t2_ready_back", if0.in_ready, 1);

        // backpressure in DONE
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (if0.out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_reach_done", found, 1);
        if0.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_ovalid", if0.out_valid, 1);
            check("t3_ready", if0.in_ready, 0);
            check("t3_shift", shift0, 0);
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        @(negedge clk);
        check("t3_ovalid_drop", if0.out_valid, 0);
        check("t3_busy", busy0, 0);
        check("t3_ready_back", if0.in_ready, 1);
        check("t3_cnt", cnt0, 2);

        // streaming with both sides always willing
        pulses = 0;
        if0.in_valid = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (shift0) begin
                if (pulses < 5) stamp[pulses] = cyc;
                pulses++;
                if (pulses == 5) if0.in_valid = 1'b0;
            end
            if (pulses >= 5 && cnt0 == 16'd7) break;
        end
        if0.in_valid = 1'b0;
        check("t4_pulses", pulses, 5);
        for (int i = 1; i < 5; i++)
            check("t4_spacing", stamp[i] - stamp[i-1], 105);
        check("t4_cnt", cnt0, 7);

        // asynchronous reset mid-MAC
        if0.in_valid = 1'b1;
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ptr0 == 7'd37) begin
                found = 1'b1;
                break;
            end
        end
        check("t1_reach_37", found, 1);
        check("t1_en_mid", en0, 1);
        #1 rst = 1'b0;
        #1;
        check("t1_ptr", ptr0, 0);
        check("t1_en", en0, 0);
        check("t1_last", last0, 0);
        check("t1_busy", busy0, 0);
        check("t1_ready", if0.in_ready, 0);
        check("t1_ovalid", if0.out_valid, 0);
        check("t1_cnt", cnt0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t1_ready_back", if0.in_ready, 1);
        check("t1_ptr_back", ptr0, 0);
        if0.in_valid = 1'b1;
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        @(negedge clk);
        check("t1_clr", clr0, 1);
        check("t1_shift_again", shift0, 1);

        // zero-latency MAC, four taps
        if1.out_ready = 1'b1;
        if1.in_valid  = 1'b1;
        @(posedge clk);
        #1 if1.in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("t5_shift", shift1, c == 1);
            check("t5_en", en1, c >= 2 && c <= 5);
            check("t5_ptr", ptr1, (c >= 2 && c <= 5) ? c - 2 : 0);
            check("t5_last", last1, c == 5);
            check("t5_ovalid", if1.out_valid, c == 6);
        end
        @(negedge clk);
        check("t5_busy", busy1, 0);
        check("t5_cnt", cnt1, 1);

        // 2-bit output counter wrap
        if2.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if2.in_valid = 1'b1;
            @(posedge clk);
            #1 if2.in_valid = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (!busy2) begin
                    found = 1'b1;
                    break;
                end
            end
            check("t6_done", found, 1);
            check("t6_cnt", cnt2, seq[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
